// File: rtl/serial_chunk_adder_pkg.sv
// Shared definitions for the serial chunk adder: FSM state encoding and
// helpers that derive the chunk count and chunk-index width.
package serial_chunk_adder_pkg;

  // Control states: IDLE accepts operands, RUN adds one chunk per cycle,
  // DONE presents the result until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-wide slices in a WIDTH-bit operand (guarded against CHUNK=0
  // so that the elaboration check in the top can report the real problem).
  function automatic int calc_nchunk(input int width, input int chunk);
    if (chunk < 1) return 1;
    return width / chunk;
  endfunction

  // Width of the chunk index; a single-chunk design still needs one bit.
  function automatic int calc_idx_w(input int nchunk);
    int w;
    w = $clog2(nchunk);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             c_o,
  output logic             msb_c_o
);

  // Ripple the carry through CHUNK full-adder cells, LSB first.
  always_comb begin
    logic [CHUNK:0] c;
    c     = '0;
    sum_o = '0;
    c[0]  = c_i;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c_o     = c[CHUNK];
    msb_c_o = c[CHUNK-1];
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// Serial adder that processes a WIDTH-bit add CHUNK bits per clock.
// Handshake: an operand set transfers on a rising edge where in_valid=1 and
// in_ready=1; a result transfers on a rising edge where out_valid=1 and
// out_ready=1. in_ready is high only in IDLE, out_valid only in DONE, so the
// block holds one operation at a time.
// Optional feature: define SERIAL_CHUNK_ADDER_SUB_EN to add the 'sub' input,
// which turns the operation into a - b - cin (cout=1 means no borrow).
// dbg_state mirrors the FSM state for observation.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(NCHUNK);

  // Reject parameter sets where the operand does not split into whole chunks.
  generate
    if ((CHUNK < 1) || (WIDTH < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               sub_eff;
  logic [CHUNK-1:0]   a_chunk, b_chunk, sum_chunk;
  logic               chunk_co, chunk_msb_ci;
  logic               last_chunk;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // Select the operand chunk addressed by the chunk index.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  assign last_chunk = (k_q == IDX_W'(NCHUNK - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a_i     (a_chunk),
    .b_i     (b_chunk),
    .c_i     (carry_q),
    .sum_o   (sum_chunk),
    .c_o     (chunk_co),
    .msb_c_o (chunk_msb_ci)
  );

  // Next-state logic: capture on accept, one chunk per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + ~cin, so invert B and the carry-in here.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub_eff}};
          carry_d = cin ^ sub_eff;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (k_q == IDX_W'(i)) s_d[i*CHUNK +: CHUNK] = sum_chunk;
        end
        carry_d = chunk_co;
        k_d     = k_q + 1'b1;
        if (last_chunk) begin
          k_d     = '0;
          cout_d  = chunk_co;
          ovf_d   = chunk_msb_ci ^ chunk_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: a 16/4 instance driven from a vector table
// plus directed backpressure and mid-run reset sequences, and an 8/8 instance
// for the single-chunk case. Define SERIAL_CHUNK_ADDER_SUB_EN to add the
// subtraction checks.
module tb_serial_chunk_adder;

  localparam int NCH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a, b, s;
  logic        cin, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;
  logic [1:0]  dbg_state;

  logic [7:0]  a8, b8, s8;
  logic        cin8, in_valid8, in_ready8, cout8, ovf8, out_valid8, out_ready8;
  logic [1:0]  dbg_state8;

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .sub(sub),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .in_valid(in_valid8), .in_ready(in_ready8), .s(s8), .cout(cout8), .ovf(ovf8),
    .out_valid(out_valid8), .out_ready(out_ready8), .dbg_state(dbg_state8)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  // Reference: {s, cout, ovf} for a + b' + cin' with b'/cin' inverted when subtracting.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    logic [15:0] bb;
    logic        ci, v;
    logic [16:0] r;
    bb = msub ? ~mb : mb;
    ci = msub ? ~mcin : mcin;
    r  = {1'b0, ma} + {1'b0, bb} + {16'd0, ci};
    v  = (ma[15] == bb[15]) && (r[15] != ma[15]);
    return {r[15:0], r[16], v};
  endfunction
`endif

  // ---------------- driver ----------------
  // Starts at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tcin,
                        input logic tsub, input string name);
    int lat;
    logic [17:0] exp;
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    // Scramble the operands after the accept edge: the result must not change.
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, NCH);
    exp = exp_q.pop_front();
    chk({name, "_result"}, {14'd0, s, cout, ovf}, {14'd0, exp});
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vecs[9] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a8 = '0; b8 = '0; cin8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_s",         {16'd0, s},         32'd0);
    chk("rst_cout",      {31'd0, cout},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_state",     {30'd0, dbg_state}, 32'd0);
    chk("rst8_in_ready", {31'd0, in_ready8}, 32'd1);

    // First accept lands on the first rising edge after reset release.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].s, vecs[i].cout, vecs[i].ovf});
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, $sformatf("vec%0d", i));
    end

    // Backpressure in DONE while new operands are offered.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk); a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, NCH);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk($sformatf("bp_hold_s%0d", i),   {16'd0, s},         32'h0003);
      chk($sformatf("bp_valid%0d", i),    {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_in_ready%0d", i), {31'd0, in_ready},  32'd0);
    end
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; cin = 1'b0; out_ready = 1'b1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp_idle_in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("bp_accept", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2_latency", lat, NCH);
    chk("bp2_result", {14'd0, s, cout, ovf}, {14'd0, 16'h0030, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);

    // Reset pulsed during the second RUN cycle.
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_s",         {16'd0, s},         32'd0);
    chk("mid_rst_cout",      {31'd0, cout},      32'd0);
    chk("mid_rst_ovf",       {31'd0, ovf},       32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_state",     {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({16'h2345, 1'b0, 1'b0});
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, "post_rst");

    // Single-chunk instance: latency 1.
    a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_latency", lat, 1);
    chk("w8_result", {22'd0, s8, cout8, ovf8}, {22'd0, 8'h2C, 1'b1, 1'b0});
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8b_latency", lat, 1);
    chk("w8b_result", {22'd0, s8, cout8, ovf8}, {22'd0, 8'h80, 1'b0, 1'b1});
    @(posedge clk);
    @(negedge clk);

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    exp_q.push_back({16'hFFFE, 1'b0, 1'b0});
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_5_7");
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rc, rs));
      run_op(ra, rb, rc, rs, $sformatf("rnd%0d", i));
    end
`endif

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
